// File: rtl/fifo.sv
// Synchronous FIFO with registered read data and async active-high reset.
// Define FIFO_STATUS_EN to add count plus sticky overflow/underflow ports.
module fifo #(
    parameter int data_width    = 8,
    parameter int depth         = 8,
    parameter int address_lines = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    write_en,
    input  logic                    read_en,
    input  logic [data_width-1:0]   din,
    output logic [data_width-1:0]   dout,
    output logic                    empty,
`ifdef FIFO_STATUS_EN
    output logic [address_lines:0]  count,
    output logic                    overflow,
    output logic                    underflow,
`endif
    output logic                    full
);

    localparam logic [address_lines:0] C_FULL = (address_lines + 1)'(depth);
    localparam logic [address_lines:0] C_ONE  = (address_lines + 1)'(1);

    logic [data_width-1:0]    r_mem [depth];
    logic [address_lines-1:0] r_wr_ptr;
    logic [address_lines-1:0] r_rd_ptr;
    logic [address_lines:0]   r_count;
    logic [address_lines:0]   w_count_nxt;
    logic                     w_wr;
    logic                     w_rd;

    assign empty = (r_count == '0);
    assign full  = (r_count == C_FULL);
    assign w_rd  = read_en && !empty;
    // A read frees a slot on the same edge, so a full FIFO still takes the write.
    assign w_wr  = write_en && (!full || read_en);

    always_comb begin
        w_count_nxt = r_count;
        unique case ({w_wr, w_rd})
            2'b10:   w_count_nxt = r_count + C_ONE;
            2'b01:   w_count_nxt = r_count - C_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage is not reset; stale entries are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            dout     <= '0;
        end else begin
            r_count <= w_count_nxt;
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                dout     <= r_mem[r_rd_ptr];
            end
        end
    end

`ifdef FIFO_STATUS_EN
    logic r_overflow;
    logic r_underflow;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (write_en && full) begin
                r_overflow <= 1'b1;
            end
            if (read_en && empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign count     = r_count;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`else
    // Core-only build: occupancy stays internal and no sticky flags exist.
`endif

endmodule

// File: tb/tb_fifo.sv
// Self-checking bench for fifo: directed scenarios then random traffic,
// all compared against a queue-based reference model.
module tb_fifo;

    localparam int DEPTH = 8;

    logic       clk;
    logic       rst;
    logic       write_en;
    logic       read_en;
    logic [7:0] din;
    logic [7:0] dout;
    logic       empty;
    logic       full;
`ifdef FIFO_STATUS_EN
    logic [3:0] count;
    logic       overflow;
    logic       underflow;
`endif

    fifo #(
        .data_width    (8),
        .depth         (DEPTH),
        .address_lines (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .write_en (write_en),
        .read_en  (read_en),
        .din      (din),
        .dout     (dout),
        .empty    (empty),
`ifdef FIFO_STATUS_EN
        .count    (count),
        .overflow (overflow),
        .underflow(underflow),
`endif
        .full     (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] q[$];
    logic [7:0] exp_dout;
    logic       exp_ovf;
    logic       exp_udf;
    int         n_tests;
    int         n_fail;
    logic [7:0] fill_v [8];
    logic [7:0] sent [$];

    task automatic check(input string tag);
        logic e_empty;
        logic e_full;
        e_empty = (q.size() == 0);
        e_full  = (q.size() == DEPTH);
        n_tests++;
        assert (dout === exp_dout) else begin
            n_fail++;
            $error("FAIL %s dout got %h want %h", tag, dout, exp_dout);
        end
        n_tests++;
        assert (empty === e_empty) else begin
            n_fail++;
            $error("FAIL %s empty got %b want %b", tag, empty, e_empty);
        end
        n_tests++;
        assert (full === e_full) else begin
            n_fail++;
            $error("FAIL %s full got %b want %b", tag, full, e_full);
        end
`ifdef FIFO_STATUS_EN
        n_tests++;
        assert (count === 4'(q.size())) else begin
            n_fail++;
            $error("FAIL %s count got %0d want %0d", tag, count, q.size());
        end
        n_tests++;
        assert (overflow === exp_ovf) else begin
            n_fail++;
            $error("FAIL %s overflow got %b want %b", tag, overflow, exp_ovf);
        end
        n_tests++;
        assert (underflow === exp_udf) else begin
            n_fail++;
            $error("FAIL %s underflow got %b want %b", tag, underflow, exp_udf);
        end
`endif
    endtask

    // Drive one clock edge and advance the reference model by the FIFO rules.
    task automatic step(input logic we, input logic re,
                        input logic [7:0] d, input string tag);
        bit m_full;
        bit m_empty;
        @(negedge clk);
        write_en = we;
        read_en  = re;
        din      = d;
        @(posedge clk);
        m_full  = (q.size() == DEPTH);
        m_empty = (q.size() == 0);
        if (we && m_full)  exp_ovf = 1'b1;
        if (re && m_empty) exp_udf = 1'b1;
        if (re && !m_empty) exp_dout = q.pop_front();
        if (we && (!m_full || re)) q.push_back(d);
        #1;
        check(tag);
    endtask

    task automatic model_reset();
        q.delete();
        exp_dout = 8'h00;
        exp_ovf  = 1'b0;
        exp_udf  = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        fill_v   = '{8'hCC, 8'h98, 8'hDC, 8'hCC, 8'hFC, 8'h4C, 8'h04, 8'hCD};
        write_en = 1'b0;
        read_en  = 1'b0;
        din      = 8'h00;
        model_reset();

        // Reset state
        rst = 1'b1;
        #12;
        check("reset");
        @(negedge clk);
        rst = 1'b0;

        // Fill, then a dropped ninth write
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, fill_v[i], "fill");
        step(1'b1, 1'b0, 8'hC8, "fill_overflow");

        // Drain in order, then reads while empty hold dout
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 8'h00, "drain");
            n_tests++;
            assert (dout === fill_v[i]) else begin
                n_fail++;
                $error("FAIL drain_order got %h want %h", dout, fill_v[i]);
            end
        end
        step(1'b0, 1'b1, 8'h00, "drain_underflow");
        step(1'b0, 1'b1, 8'h00, "drain_underflow");
        n_tests++;
        assert (dout === 8'hCD) else begin
            n_fail++;
            $error("FAIL drain_hold got %h want cd", dout);
        end

        // Pointer wrap-around: write 5, read 5, write 8, read 8
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'($urandom), "wrap_w5");
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'h00, "wrap_r5");
        sent.delete();
        for (int i = 0; i < 8; i++) begin
            sent.push_back(8'($urandom));
            step(1'b1, 1'b0, sent[i], "wrap_w8");
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 8'h00, "wrap_r8");
            n_tests++;
            assert (dout === sent[i]) else begin
                n_fail++;
                $error("FAIL wrap_order got %h want %h", dout, sent[i]);
            end
        end

        // Simultaneous access at count 3
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'($urandom), "sim3_pre");
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 8'($urandom), "sim3");
        n_tests++;
        assert (q.size() == 3 && !empty && !full) else begin
            n_fail++;
            $error("FAIL sim3_level got empty=%b full=%b want 0/0", empty, full);
        end

        // Simultaneous access while full
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'($urandom), "simf_pre");
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 8'($urandom), "simf");
        n_tests++;
        assert (full === 1'b1) else begin
            n_fail++;
            $error("FAIL simf_level got full=%b want 1", full);
        end

        // Simultaneous access while empty: only the write happens
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'h00, "sime_pre");
        step(1'b1, 1'b1, 8'h5A, "sime");
        n_tests++;
        assert (q.size() == 1 && empty === 1'b0) else begin
            n_fail++;
            $error("FAIL sime_level got empty=%b want 0", empty);
        end
        step(1'b0, 1'b1, 8'h00, "sime_read");
        n_tests++;
        assert (dout === 8'h5A) else begin
            n_fail++;
            $error("FAIL sime_data got %h want 5a", dout);
        end

        // Mid-operation asynchronous reset with 4 entries held
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'($urandom), "mrst_pre");
        @(negedge clk);
        write_en = 1'b0;
        read_en  = 1'b0;
        rst      = 1'b1;
        #1;
        model_reset();
        check("mid_reset");
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 1'b0, 8'hA7, "mrst_write");
        step(1'b0, 1'b1, 8'h00, "mrst_read");
        n_tests++;
        assert (dout === 8'hA7) else begin
            n_fail++;
            $error("FAIL mrst_data got %h want a7", dout);
        end

        // Random traffic: write-heavy phase, then read-heavy phase
        for (int i = 0; i < 400; i++) begin
            int wbias;
            wbias = (i < 200) ? 70 : 30;
            step(($urandom_range(0, 99) < wbias) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 100 - wbias) ? 1'b1 : 1'b0,
                 8'($urandom), "random");
        end

        @(negedge clk);
        write_en = 1'b0;
        read_en  = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo.md
FIFO -- requirements
Module: fifo

Interface
REQ-001 SHALL have parameter data_width, default 8: width of din/dout in bits.
REQ-002 SHALL have parameter depth, default 8: number of storage entries.
REQ-003 SHALL have parameter address_lines, default 3: pointer width; depth == 2**address_lines.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port write_en, input, 1: write request.
REQ-007 SHALL have port read_en, input, 1: read request.
REQ-008 SHALL have port din, input, data_width: write data.
REQ-009 SHALL have port dout, output, data_width: registered read data.
REQ-010 SHALL have port empty, output, 1: high when occupancy == 0.
REQ-011 SHALL have port full, output, 1: high when occupancy == depth.
REQ-012 SHALL, with FIFO_STATUS_EN defined, have ports count (output, address_lines+1: occupancy), overflow (output, 1: sticky) and underflow (output, 1: sticky).

Function
REQ-013 SHALL be a synchronous FIFO: write pointer, read pointer (address_lines bits each) and occupancy counter (address_lines+1 bits).
REQ-014 SHALL, on a rising edge with write_en=1 and full=0, store din at the write pointer and increment the write pointer modulo depth.
REQ-015 SHALL, on a rising edge with read_en=1 and empty=0, load dout with the entry at the read pointer and increment the read pointer modulo depth; read latency is one clock edge.
REQ-016 SHALL ignore a write while full: no memory, pointer or count change.
REQ-017 SHALL ignore a read while empty: dout holds its last value and the pointers do not move.
REQ-018 SHALL, on a simultaneous valid read and write, perform both operations and leave the count unchanged.
REQ-019 SHALL, when full with write_en=1 and read_en=1, perform the read and also accept the write, leaving the count at depth.
REQ-020 SHALL, when empty with write_en=1 and read_en=1, perform only the write: count becomes 1 and dout is unchanged.
REQ-021 SHALL drive empty and full combinationally from the count; they are never asserted together.
REQ-022 SHALL wrap both pointers from depth-1 to 0 without data loss; data SHALL be returned in strict write order.
REQ-023 SHALL hold the count within 0..depth under all input sequences.

Reset
REQ-024 SHALL, while rst=1, asynchronously clear both pointers, count and dout to 0, and set empty=1 and full=0.
REQ-025 SHALL NOT clear memory contents on reset; stale data is unreachable because the pointers are cleared.
REQ-026 SHALL discard all stored entries when reset is asserted mid-operation; the first write after reset lands at address 0.

Configuration
REQ-027 SHALL, with macro FIFO_STATUS_EN defined, expose count, set overflow on any write attempted while full, and set underflow on any read attempted while empty; both flags clear only on reset.
REQ-028 SHALL, without FIFO_STATUS_EN, omit the count, overflow and underflow ports and their logic; core behaviour is identical in both builds.

Verification
REQ-029 SHALL verify reset: assert rst, then check empty=1, full=0, dout=0x00 (and count=0 when FIFO_STATUS_EN is defined).
REQ-030 SHALL verify fill: 8 writes of CC,98,DC,CC,FC,4C,04,CD -> full=1 after the 8th edge; a 9th write of C8 is dropped (overflow=1 when FIFO_STATUS_EN is defined).
REQ-031 SHALL verify drain: continuous read_en -> dout sequence CC,98,DC,CC,FC,4C,04,CD, one per edge; then empty=1, and further reads hold dout=CD (underflow=1 when FIFO_STATUS_EN is defined).
REQ-032 SHALL verify wrap-around: write 5, read 5, write 8 values -> all 8 read back in order across the pointer wrap.
REQ-033 SHALL verify simultaneous access: with count=3, write_en=1 and read_en=1 for 10 edges -> count stays 3 and output order is preserved; the same with full -> count stays 8; the same with empty -> count becomes 1.
REQ-034 SHALL verify mid-operation reset: with 4 entries held, pulse rst -> empty=1 immediately (asynchronous); the next write/read pair returns the newly written value.
